// File: rtl/screen_sequencer.sv
// Screen control FSM: selects the full-screen image, restarts and times each drawer
// sweep, and hands the VGA write port between the fill drawer and the game logic.
module screen_sequencer #(
   parameter int unsigned FILL_CYCLES  = 19200,
   parameter int unsigned FLASH_PERIOD = 12_500_000,
   parameter int unsigned FLASH_COUNT  = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic start_n,
   input  logic game_over,
   output logic draw_rst_n,
   output logic show_title,
   output logic show_black,
   output logic show_gameover,
   output logic flash,
   output logic draw_active,
   output logic game_enable
);

   localparam int unsigned DRAW_W  = 15;
   localparam int unsigned PHASE_W = $clog2(FLASH_PERIOD + 1);
   localparam int unsigned PAIR_W  = 4;

   localparam logic [DRAW_W-1:0]  DRAW_LAST  = DRAW_W'(FILL_CYCLES + 1);
   localparam logic [DRAW_W-1:0]  DRAW_DONE  = DRAW_W'(FILL_CYCLES + 2);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FLASH_PERIOD - 1);
   localparam logic [PAIR_W-1:0]  PAIR_LAST  = PAIR_W'(FLASH_COUNT - 1);

   typedef enum logic [2:0] {
      TITLE_DRAW,
      TITLE_WAIT,
      CLEAR_DRAW,
      PLAY,
      FLASH_ON,
      FLASH_OFF,
      GAMEOVER_DRAW,
      GAMEOVER_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [DRAW_W-1:0]   draw_cnt_q, draw_cnt_d;
   logic [PHASE_W-1:0]  phase_cnt_q, phase_cnt_d;
   logic [PAIR_W-1:0]   pair_cnt_q, pair_cnt_d;
   logic [2:0]          sync_q;
   logic                press_q;

   logic                draw_rst_n_d;
   logic                show_title_d;
   logic                show_black_d;
   logic                show_gameover_d;
   logic                flash_d;
   logic                draw_active_d;
   logic                game_enable_d;

   // Two-flop synchronizer plus a third flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q  <= '1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], start_n};
         press_q <= sync_q[2] & ~sync_q[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= TITLE_DRAW;
         draw_cnt_q    <= '0;
         phase_cnt_q   <= '0;
         pair_cnt_q    <= '0;
         draw_rst_n    <= 1'b0;
         show_title    <= 1'b1;
         show_black    <= 1'b0;
         show_gameover <= 1'b0;
         flash         <= 1'b0;
         draw_active   <= 1'b1;
         game_enable   <= 1'b0;
      end else begin
         state_q       <= state_d;
         draw_cnt_q    <= draw_cnt_d;
         phase_cnt_q   <= phase_cnt_d;
         pair_cnt_q    <= pair_cnt_d;
         draw_rst_n    <= draw_rst_n_d;
         show_title    <= show_title_d;
         show_black    <= show_black_d;
         show_gameover <= show_gameover_d;
         flash         <= flash_d;
         draw_active   <= draw_active_d;
         game_enable   <= game_enable_d;
      end
   end

   // Next state, counters, and outputs decoded from the upcoming state.
   always_comb begin
      state_d         = state_q;
      draw_cnt_d      = (draw_cnt_q == DRAW_DONE) ? draw_cnt_q : draw_cnt_q + DRAW_W'(1);
      phase_cnt_d     = phase_cnt_q + PHASE_W'(1);
      pair_cnt_d      = pair_cnt_q;
      draw_rst_n_d    = 1'b0;
      show_title_d    = 1'b0;
      show_black_d    = 1'b0;
      show_gameover_d = 1'b0;
      flash_d         = 1'b0;
      draw_active_d   = 1'b1;
      game_enable_d   = 1'b0;

      case (state_q)
         TITLE_DRAW:    if (draw_cnt_q == DRAW_LAST) state_d = TITLE_WAIT;
         TITLE_WAIT:    if (press_q) state_d = CLEAR_DRAW;
         CLEAR_DRAW:    if (draw_cnt_q == DRAW_LAST) state_d = PLAY;
         PLAY: begin
            if (game_over) begin
               state_d    = FLASH_ON;
               pair_cnt_d = '0;
            end
         end
         FLASH_ON:      if (phase_cnt_q == PHASE_LAST) state_d = FLASH_OFF;
         FLASH_OFF: begin
            if (phase_cnt_q == PHASE_LAST) begin
               pair_cnt_d = pair_cnt_q + PAIR_W'(1);
               state_d    = (pair_cnt_q == PAIR_LAST) ? GAMEOVER_DRAW : FLASH_ON;
            end
         end
         GAMEOVER_DRAW: if (draw_cnt_q == DRAW_LAST) state_d = GAMEOVER_WAIT;
         GAMEOVER_WAIT: if (press_q) state_d = CLEAR_DRAW;
         default:       state_d = TITLE_DRAW;
      endcase

      if (state_d != state_q) begin
         draw_cnt_d  = '0;
         phase_cnt_d = '0;
      end

      case (state_d)
         TITLE_DRAW, TITLE_WAIT:                 show_title_d    = 1'b1;
         CLEAR_DRAW:                             show_black_d    = 1'b1;
         FLASH_ON, GAMEOVER_DRAW, GAMEOVER_WAIT: show_gameover_d = 1'b1;
         FLASH_OFF:                              flash_d         = 1'b1;
         default: begin
            draw_active_d = 1'b0;
            game_enable_d = 1'b1;
         end
      endcase

      // Sweep runs from the cycle after entry until the count saturates; parked otherwise.
      case (state_d)
         TITLE_DRAW, CLEAR_DRAW, FLASH_ON, FLASH_OFF, GAMEOVER_DRAW:
            draw_rst_n_d = (draw_cnt_d != '0) && (draw_cnt_d != DRAW_DONE);
         default: draw_rst_n_d = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed vector table, hand sequences for held button
// and mid-flash reset, then random stimulus against a phase/duration reference model.
module tb_screen_sequencer;

   localparam int FILL   = 16;
   localparam int PERIOD = 40;
   localparam int COUNT  = 2;

   logic clk = 1'b0;
   logic rst, start_n, game_over;
   logic draw_rst_n, show_title, show_black, show_gameover, flash, draw_active, game_enable;

   always #5 clk = ~clk;

   screen_sequencer #(
      .FILL_CYCLES (FILL),
      .FLASH_PERIOD(PERIOD),
      .FLASH_COUNT (COUNT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_n      (start_n),
      .game_over    (game_over),
      .draw_rst_n   (draw_rst_n),
      .show_title   (show_title),
      .show_black   (show_black),
      .show_gameover(show_gameover),
      .flash        (flash),
      .draw_active  (draw_active),
      .game_enable  (game_enable)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: which screen is showing and for how long.
   typedef enum int {M_TITLE_DRAW, M_TITLE_WAIT, M_CLEAR, M_PLAY,
                     M_ON, M_OFF, M_GO_DRAW, M_GO_WAIT} mode_t;
   mode_t    mode  = M_TITLE_DRAW;
   int       t     = 0;
   int       pairs = 0;
   bit [3:0] hist  = 4'hF;

   function automatic int dur(input mode_t m);
      case (m)
         M_TITLE_DRAW, M_CLEAR, M_GO_DRAW: return FILL + 2;
         M_ON, M_OFF:                      return PERIOD;
         default:                          return 0;
      endcase
   endfunction

   function automatic logic [6:0] model_out();
      logic [3:0] sel;
      logic       drn;
      case (mode)
         M_TITLE_DRAW, M_TITLE_WAIT: sel = 4'b1000;
         M_CLEAR:                    sel = 4'b0100;
         M_ON, M_GO_DRAW, M_GO_WAIT: sel = 4'b0010;
         M_OFF:                      sel = 4'b0001;
         default:                    sel = 4'b0000;
      endcase
      drn = (dur(mode) != 0) && (t >= 1) && (t <= FILL + 1);
      return {drn, sel, mode != M_PLAY, mode == M_PLAY};
   endfunction

   task automatic model_step(input bit r, input bit s, input bit g);
      mode_t nxt;
      bit    press;
      if (!r) begin
         mode  = M_TITLE_DRAW;
         t     = 0;
         pairs = 0;
         hist  = 4'hF;
      end else begin
         // Press seen by the FSM: a 1->0 step of the sample taken four edges back.
         press = hist[3] && !hist[2];
         nxt   = mode;
         if (dur(mode) != 0 && t + 1 == dur(mode)) begin
            case (mode)
               M_TITLE_DRAW: nxt = M_TITLE_WAIT;
               M_CLEAR:      nxt = M_PLAY;
               M_ON:         nxt = M_OFF;
               M_OFF: begin
                  pairs++;
                  nxt = (pairs == COUNT) ? M_GO_DRAW : M_ON;
               end
               default:      nxt = M_GO_WAIT;
            endcase
         end else if ((mode == M_TITLE_WAIT || mode == M_GO_WAIT) && press) begin
            nxt = M_CLEAR;
         end else if (mode == M_PLAY && g) begin
            nxt   = M_ON;
            pairs = 0;
         end
         t    = (nxt != mode) ? 0 : t + 1;
         mode = nxt;
         hist = {hist[2:0], s};
      end
   endtask

   function automatic logic [6:0] dut_out();
      return {draw_rst_n, show_title, show_black, show_gameover, flash, draw_active, game_enable};
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance model, sample on the falling edge.
   task automatic tick(input bit r, input bit s, input bit g);
      logic [3:0] sel;
      rst       = r;
      start_n   = s;
      game_over = g;
      @(posedge clk);
      model_step(r, s, g);
      @(negedge clk);
      sel = {show_title, show_black, show_gameover, flash};
      check("model", dut_out(), model_out());
      check("sel_onehot0", {6'b0, $onehot0(sel)}, 7'd1);
      check("port_owner", {6'b0, draw_active == !game_enable}, 7'd1);
   endtask

   typedef struct {
      bit         r;
      bit         s;
      bit         g;
      int         n;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int clears;
      bit s_rand;
      rst       = 1'b0;
      start_n   = 1'b1;
      game_over = 1'b0;

      // Encoding: {draw_rst_n, title, black, gameover, flash, draw_active, game_enable}
      vecs.push_back('{0, 1, 0, 2,  7'b0100010}); // reset held: title entry
      vecs.push_back('{1, 1, 0, 17, 7'b1100010}); // title sweep
      vecs.push_back('{1, 1, 0, 3,  7'b0100010}); // title wait, parked
      vecs.push_back('{1, 0, 0, 3,  7'b0100010}); // press in synchronizer
      vecs.push_back('{1, 0, 0, 1,  7'b0010010}); // clear entry
      vecs.push_back('{1, 1, 0, 17, 7'b1010010}); // clear sweep
      vecs.push_back('{1, 0, 0, 3,  7'b0000001}); // play, press ignored
      vecs.push_back('{1, 1, 0, 4,  7'b0000001});
      vecs.push_back('{1, 1, 1, 1,  7'b0001010}); // game over -> flash on entry
      for (int k = 0; k < COUNT; k++) begin
         if (k > 0) vecs.push_back('{1, 1, 0, 1, 7'b0001010});
         vecs.push_back('{1, 1, 0, 17, 7'b1001010});
         vecs.push_back('{1, 1, 0, 22, 7'b0001010});
         vecs.push_back('{1, 1, 0, 1,  7'b0000110});
         vecs.push_back('{1, 1, 0, 17, 7'b1000110});
         vecs.push_back('{1, 1, 0, 22, 7'b0000110});
      end
      vecs.push_back('{1, 1, 0, 1,  7'b0001010}); // game-over draw entry
      vecs.push_back('{1, 1, 0, 17, 7'b1001010});
      vecs.push_back('{1, 1, 0, 5,  7'b0001010}); // game-over wait

      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].n; c++) begin
            tick(vecs[i].r, vecs[i].s, vecs[i].g);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
         end
      end

      // Button held 200 cycles in game-over wait: exactly one clear, then play.
      clears = 0;
      for (int c = 0; c < 200; c++) begin
         tick(1, 0, 0);
         if (show_black && !draw_rst_n) clears++;
      end
      check("held_one_clear", 7'(clears), 7'd1);
      check("held_in_play", {6'b0, game_enable}, 7'd1);
      for (int c = 0; c < 5; c++) tick(1, 1, 0);

      // Reset in the middle of a flash-off phase.
      tick(1, 1, 1);
      for (int c = 0; c < 2 * PERIOD && !flash; c++) tick(1, 1, 0);
      check("reach_flash_off", {6'b0, flash}, 7'd1);
      for (int c = 0; c < 10; c++) tick(1, 1, 0);
      tick(0, 1, 0);
      check("rst_mid_flash", dut_out(), 7'b0100010);
      tick(1, 1, 0);
      check("rst_release", dut_out(), 7'b1100010);

      // Random stimulus against the model.
      s_rand = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(7) == 0) s_rand = ~s_rand;
         tick(($urandom_range(599) != 0), s_rand, ($urandom_range(15) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen control FSM sitting directly upstream of the full-screen fill drawer. It decides which full-screen image is painted: title, black clear, game-over, or the flashing game-over variant. It restarts the drawer's pixel sweep for each paint and times each sweep to completion. It also hands the VGA write port to the snake game logic during play, and steps through title → play → game-over flash → game-over wait.

## Interface
Parameters:
- FILL_CYCLES, 19200: pixels per full-screen sweep (160×120).
- FLASH_PERIOD, 12_500_000: cycles per flash phase; must be ≥ FILL_CYCLES+2.
- FLASH_COUNT, 3: number of on/off flash pairs before settling on the game-over image.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start_n  in  1  raw push-button, active-low, asynchronous to clk.
- game_over  in  1  level from game logic; sampled only in PLAY.
- draw_rst_n  out  1  drives drawer rst; low parks/restarts its address at 0.
- show_title  out  1  drawer select: title image.
- show_black  out  1  drawer select: black fill.
- show_gameover  out  1  drawer select: game-over image.
- flash  out  1  drawer select: game-over image with red mapped to black.
- draw_active  out  1  high when the drawer owns the VGA write port; top-level mux selects drawer x/y/colour/wren.
- game_enable  out  1  high only in PLAY; game logic runs and owns the VGA port.

## Operation
- Input conditioning: start_n passes through a 2-flop synchronizer. A press event is a one-cycle pulse on the synchronized 1→0 edge. Press events are honoured only in TITLE_WAIT and GAMEOVER_WAIT, and are discarded elsewhere.
- Selects are one-hot or all-zero. At most one of show_title/show_black/show_gameover/flash is high at any time.
- Draw sub-sequence (all *_DRAW states):
  - Entry cycle: draw_rst_n=0.
  - Next FILL_CYCLES+1 cycles: draw_rst_n=1. The extra cycle covers the drawer's 1-cycle ROM latency.
  - Then transition.
  - The select stays constant for the whole sub-sequence.
  - Draw counter: 15-bit, cleared on state entry.
- Outside draw states, draw_rst_n=0 (drawer parked on pixel 0). The select is held unchanged so the parked write repaints an identical pixel.
- States and transitions:
  - TITLE_DRAW (show_title): draw complete → TITLE_WAIT.
  - TITLE_WAIT (show_title): press → CLEAR_DRAW.
  - CLEAR_DRAW (show_black): draw complete → PLAY.
  - PLAY (all selects 0, draw_active=0, game_enable=1): game_over=1 → FLASH_ON; flash pair counter cleared.
  - FLASH_ON (show_gameover): draw, then hold until FLASH_PERIOD cycles from entry → FLASH_OFF.
  - FLASH_OFF (flash): draw, then hold until FLASH_PERIOD cycles from entry. Pair counter +1. If counter = FLASH_COUNT → GAMEOVER_DRAW, else → FLASH_ON.
  - GAMEOVER_DRAW (show_gameover): draw complete → GAMEOVER_WAIT.
  - GAMEOVER_WAIT (show_gameover): press → CLEAR_DRAW.
- The phase counter is wide enough for FLASH_PERIOD (24 bits at default). The pair counter is 4 bits.
- draw_active=1 in every state except PLAY. game_enable=1 only in PLAY.

## Timing
- Reset (rst=0 at a clk edge):
  - State goes to TITLE_DRAW entry.
  - draw_rst_n=0, show_title=1, all other selects 0.
  - draw_active=1, game_enable=0.
  - All counters 0, synchronizer flops 1.
- First cycle after rst rises is the TITLE_DRAW entry cycle (draw_rst_n=0). draw_rst_n rises on the following cycle.
- A draw state occupies exactly FILL_CYCLES+2 cycles.
- Press latency: start_n falling → synchronizer → edge pulse (3 clk edges) → state change on the next edge.
- game_over in PLAY: FLASH_ON is entered on the next edge. draw_active rises in the same cycle game_enable falls, with no overlap.
- A flash phase lasts exactly FLASH_PERIOD cycles including its draw.
- Simultaneous press and game_over: each is only relevant in disjoint states, so no conflict.
- A held button produces one press event only.
- Reset mid-draw or mid-flash: abandon immediately to TITLE_DRAW entry. Counters clear.

## Test plan
Bench parameters: FILL_CYCLES=16, FLASH_PERIOD=40, FLASH_COUNT=2.
- Reset release → draw_rst_n low 1 cycle, then high 17 cycles with show_title=1; state TITLE_WAIT at cycle 18 with draw_rst_n=0.
- Press in TITLE_WAIT → show_black draw of 18 cycles; then game_enable=1, draw_active=0, all selects 0.
- game_over in PLAY → selects alternate show_gameover/flash every 40 cycles (on, off, on, off). Then an 18-cycle show_gameover draw, then GAMEOVER_WAIT.
- Button held 200 cycles in GAMEOVER_WAIT → exactly one CLEAR_DRAW then PLAY. Presses during draws and PLAY are ignored.
- rst low during FLASH_OFF → next cycle show_title=1, flash=0, draw_rst_n=0, game_enable=0.
- Throughout all scenarios: assert select one-hot/zero, and assert draw_active == !game_enable.
